// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel word-copy DMA engine.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

  // Byte-address step between consecutive 16-bit words
  localparam int WORD_INC = 2;

  localparam logic [1:0] WE_READ  = 2'b00;
  localparam logic [1:0] WE_WRITE = 2'b11;

endpackage

// File: rtl/dma_ptr.sv
// Loadable word-aligned address pointer with modulo-2^AW +WORD_INC increment.
module dma_ptr
  import dma_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_nxt_o
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Bit 0 is forced low on load so the pointer is always word aligned
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i & ~AW'(1);
    end else if (inc_i) begin
      ptr_d = ptr_q + AW'(WORD_INC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Value the pointer holds after the coming edge; lets the owner register it
  assign ptr_nxt_o = ptr_d;

endmodule

// File: rtl/dma_engine.sv
// Word-by-word memory copy engine: read a source word, write it to the destination,
// repeat for cfg_len words. Abort kills the transfer without advancing pointers.
//
//   state   | meaning
//   IDLE    | waiting for cfg_start
//   RD      | read request at src pointer, held until dma_ready
//   WR      | write request at dst pointer, held until dma_ready
//   DONE    | one-cycle completion pulse, then IDLE
module dma_engine
  import dma_pkg::*;
#(
  parameter int AW = 16,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cfg_src,
  input  logic [AW-1:0] cfg_dst,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_start,
  input  logic          abort,
  output logic [AW-1:0] dma_addr,
  output logic          dma_en,
  output logic [1:0]    dma_we,
  output logic [15:0]   dma_dout,
  input  logic [15:0]   dma_din,
  input  logic          dma_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] remaining
);

  dma_state_e    state_q;
  logic [AW-1:0] addr_q;
  logic          en_q;
  logic [1:0]    we_q;
  logic [15:0]   data_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [LW-1:0] rem_q;

  logic          launch;
  logic          beat_wr;
  logic          active;
  logic [AW-1:0] src_nxt;
  logic [AW-1:0] dst_nxt;

  assign launch  = (state_q == ST_IDLE) && cfg_start && (cfg_len != '0);
  assign active  = (state_q == ST_RD) || (state_q == ST_WR);
  assign beat_wr = (state_q == ST_WR) && dma_ready && !abort;

  dma_ptr #(.AW(AW)) u_src_ptr (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (launch),
    .load_val_i (cfg_src),
    .inc_i      (beat_wr),
    .ptr_nxt_o  (src_nxt)
  );

  dma_ptr #(.AW(AW)) u_dst_ptr (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (launch),
    .load_val_i (cfg_dst),
    .inc_i      (beat_wr),
    .ptr_nxt_o  (dst_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= WE_READ;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Abort wins over a same-cycle dma_ready: no beat counted, pointers frozen
      if (active && abort) begin
        state_q <= ST_IDLE;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
        en_q    <= 1'b0;
        we_q    <= WE_READ;
        addr_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cfg_start) begin
              busy_q <= 1'b1;
              if (cfg_len != '0) begin
                state_q <= ST_RD;
                rem_q   <= cfg_len;
                en_q    <= 1'b1;
                we_q    <= WE_READ;
                addr_q  <= src_nxt;
              end else begin
                state_q <= ST_DONE;
                rem_q   <= '0;
                done_q  <= 1'b1;
              end
            end
          end
          ST_RD: begin
            if (dma_ready) begin
              state_q <= ST_WR;
              data_q  <= dma_din;
              we_q    <= WE_WRITE;
              addr_q  <= dst_nxt;
            end
          end
          ST_WR: begin
            if (dma_ready) begin
              rem_q <= rem_q - LW'(1);
              if (rem_q == LW'(1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                en_q    <= 1'b0;
                we_q    <= WE_READ;
                addr_q  <= '0;
              end else begin
                state_q <= ST_RD;
                we_q    <= WE_READ;
                addr_q  <= src_nxt;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= WE_READ;
            addr_q  <= '0;
          end
        endcase
      end
    end
  end

  assign dma_addr  = addr_q;
  assign dma_en    = en_q;
  assign dma_we    = we_q;
  assign dma_dout  = (state_q == ST_WR) ? data_q : 16'h0000;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine; read data is address ^ 16'h5A5A so write data is predictable.
module tb_dma_engine;

  localparam int AW = 16;
  localparam int LW = 16;

  typedef logic [37:0] vec_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cfg_src = '0;
  logic [AW-1:0] cfg_dst = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] dma_addr;
  logic          dma_en;
  logic [1:0]    dma_we;
  logic [15:0]   dma_dout;
  logic [15:0]   dma_din;
  logic          dma_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] remaining;
  vec_t          obs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dma_engine #(.AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_src   (cfg_src),
    .cfg_dst   (cfg_dst),
    .cfg_len   (cfg_len),
    .cfg_start (cfg_start),
    .abort     (abort),
    .dma_addr  (dma_addr),
    .dma_en    (dma_en),
    .dma_we    (dma_we),
    .dma_dout  (dma_dout),
    .dma_din   (dma_din),
    .dma_ready (dma_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining)
  );

  assign dma_din = dma_addr ^ 16'h5A5A;
  assign obs = {dma_en, dma_we, dma_addr, dma_dout, busy, done, err};

  // Expected-vector builders: {en, we, addr, dout, busy, done, err}
  function automatic vec_t rd(input logic [15:0] a);
    return {1'b1, 2'b00, a, 16'h0000, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic vec_t wr(input logic [15:0] a, input logic [15:0] d);
    return {1'b1, 2'b11, a, d, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic vec_t dn();
    return {1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
  endfunction
  function automatic vec_t idl();
    return '0;
  endfunction
  function automatic vec_t er();
    return {1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    cfg_src   = s;
    cfg_dst   = d;
    cfg_len   = l;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (obs !== idl() || remaining !== 16'h0000) begin
      fails++;
      $display("FAIL reset_outputs: got %h rem %h, expected %h rem 0000", obs, remaining, idl());
    end
    #21 reset_n = 1'b1;
    tick();
    tests++;
    if (obs !== idl()) begin
      fails++;
      $display("FAIL reset_release_idle: got %h expected %h", obs, idl());
    end
  endtask

  task automatic test_basic();
    vec_t e [8];
    dma_ready = 1'b1;
    e = '{rd(16'h0200), wr(16'h0400, 16'h585A), rd(16'h0202), wr(16'h0402, 16'h5858),
          rd(16'h0204), wr(16'h0404, 16'h585E), dn(), idl()};
    start(16'h0200, 16'h0400, 16'd3);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL basic cycle %0d: got %h expected %h", i + 1, obs, e[i]);
      end
      if (i == 0) begin
        tests++;
        if (remaining !== 16'd3) begin
          fails++;
          $display("FAIL basic_rem_start: got %0d expected 3", remaining);
        end
      end
      tick();
    end
    tests++;
    if (remaining !== 16'd0) begin
      fails++;
      $display("FAIL basic_rem_end: got %0d expected 0", remaining);
    end
  endtask

  task automatic test_len_zero();
    dma_ready = 1'b1;
    start(16'h0111, 16'h0222, 16'd0);
    tests++;
    if (obs !== dn()) begin
      fails++;
      $display("FAIL len0_done: got %h expected %h", obs, dn());
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (obs !== idl() || remaining !== 16'd0) begin
      fails++;
      $display("FAIL len0_idle: got %h rem %h expected %h rem 0000", obs, remaining, idl());
    end
  endtask

  task automatic test_wrap_wait();
    vec_t e [10];
    e = '{rd(16'hFFFE), rd(16'hFFFE), wr(16'h1000, 16'hA5A4), wr(16'h1000, 16'hA5A4),
          rd(16'h0000), rd(16'h0000), wr(16'h1002, 16'h5A5A), wr(16'h1002, 16'h5A5A),
          dn(), idl()};
    dma_ready = 1'b0;
    start(16'hFFFE, 16'h1000, 16'd2);
    for (int i = 0; i < 10; i++) begin
      dma_ready = (i % 2 == 1);
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL wrap cycle %0d: got %h expected %h", i + 1, obs, e[i]);
      end
      if (i == 4) begin
        tests++;
        if (remaining !== 16'd1) begin
          fails++;
          $display("FAIL wrap_rem: got %0d expected 1", remaining);
        end
      end
      tick();
    end
    dma_ready = 1'b1;
  endtask

  task automatic test_abort();
    vec_t e [7];
    e = '{rd(16'h0300), wr(16'h0500, 16'h595A), rd(16'h0302), wr(16'h0502, 16'h5958),
          er(), idl(), idl()};
    dma_ready = 1'b1;
    start(16'h0300, 16'h0500, 16'd4);
    for (int i = 0; i < 7; i++) begin
      abort = (i == 3);
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL abort cycle %0d: got %h expected %h", i + 1, obs, e[i]);
      end
      if (i >= 4) begin
        tests++;
        if (remaining !== 16'd3) begin
          fails++;
          $display("FAIL abort_rem cycle %0d: got %0d expected 3", i + 1, remaining);
        end
      end
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    vec_t e [6];
    e = '{rd(16'h0600), wr(16'h0700, 16'h5C5A), rd(16'h0602), wr(16'h0702, 16'h5C58),
          dn(), idl()};
    dma_ready = 1'b1;
    start(16'h0600, 16'h0700, 16'd2);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        cfg_src   = 16'h0A00;
        cfg_dst   = 16'h0B00;
        cfg_len   = 16'd5;
        cfg_start = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL restart cycle %0d: got %h expected %h", i + 1, obs, e[i]);
      end
      if (i == 2) begin
        tests++;
        if (remaining !== 16'd1) begin
          fails++;
          $display("FAIL restart_rem: got %0d expected 1", remaining);
        end
      end
      tick();
    end
    cfg_start = 1'b0;
  endtask

  task automatic test_reset_mid();
    vec_t e [4];
    dma_ready = 1'b1;
    start(16'h0800, 16'h0900, 16'd3);
    tick();
    tests++;
    if (obs !== wr(16'h0900, 16'h525A)) begin
      fails++;
      $display("FAIL midrst_pre: got %h expected %h", obs, wr(16'h0900, 16'h525A));
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (obs !== idl() || remaining !== 16'd0) begin
      fails++;
      $display("FAIL midrst_async: got %h rem %h expected %h rem 0000", obs, remaining, idl());
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    tests++;
    if (obs !== idl()) begin
      fails++;
      $display("FAIL midrst_no_pulse: got %h expected %h", obs, idl());
    end
    e = '{rd(16'h0C00), wr(16'h0D00, 16'h565A), dn(), idl()};
    start(16'h0C00, 16'h0D00, 16'd1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL midrst_fresh cycle %0d: got %h expected %h", i + 1, obs, e[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    tick();
    test_len_zero();
    tick();
    test_wrap_wait();
    tick();
    test_abort();
    tick();
    test_start_ignored();
    tick();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
